mem_arbiter: RTL and testbench

Shares the single external 32-bit SRAM port between the instruction-fetch stage and the data-memory (MEM) stage of the pipeline. Accepts one request per side and grants the port to one requester at a time. Sequences the multi-cycle SRAM read/write strobes and returns data with a one-cycle ready pulse. Drives a pipeline `stall` while any request is outstanding.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_sram_port_ctrl.sv | 116 +++++++++++
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter: requester IDs,
// port-controller state encoding and default sizing.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF  = 20;
  localparam int WAIT_CYCLES_DEF = 1;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } port_state_e;

  function automatic logic is_misaligned(input logic [1:0] lowBits);
    return |lowBits;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/response signals plus the split SRAM pin bundle.
// The arbiter uses the slave view; the pipeline/SRAM environment uses master.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  if_req;
  logic [31:0]           if_addr;
  logic [31:0]           if_rdata;
  logic                  if_ready;
  logic                  dm_req;
  logic                  dm_we;
  logic [31:0]           dm_addr;
  logic [31:0]           dm_wdata;
  logic [31:0]           dm_rdata;
  logic                  dm_ready;
  logic                  dm_misalign;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_dq_o;
  logic                  sram_dq_oe;
  logic [31:0]           sram_dq_i;
  logic                  sram_ce_n;
  logic                  sram_oe_n;
  logic                  sram_we_n;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_dq_i,
    output if_rdata, if_ready, dm_rdata, dm_ready, dm_misalign, stall,
           sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_dq_i,
    input  if_rdata, if_ready, dm_rdata, dm_ready, dm_misalign, stall,
           sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );

endinterface

// File: rtl/mem_arbiter_sram_port_ctrl.sv
// SRAM access sequencer: runs one read or write per start pulse with
// registered strobes, then reports completion through a one-cycle done.
module mem_arbiter_sram_port_ctrl
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [31:0]           i_dq,
  output logic [31:0]           o_rdata,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_sramAddr,
  output logic [31:0]           o_dq,
  output logic                  o_dqOe,
  output logic                  o_ceN,
  output logic                  o_oeN,
  output logic                  o_weN
);

  port_state_e           r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_dq;
  logic [31:0]           r_rdata;
  logic                  r_dqOe;
  logic                  r_ceN;
  logic                  r_oeN;
  logic                  r_weN;
  logic                  r_done;

  // Strobes change on the same edge as the state, so every pin is a flop output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_dq    <= '0;
      r_rdata <= '0;
      r_dqOe  <= 1'b0;
      r_ceN   <= 1'b1;
      r_oeN   <= 1'b1;
      r_weN   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr <= i_addr;
            r_ceN  <= 1'b0;
            if (i_we) begin
              r_dq    <= i_wdata;
              r_dqOe  <= 1'b1;
              r_state <= ST_WR_SETUP;
            end else begin
              r_oeN   <= 1'b0;
              r_cnt   <= 4'(WAIT_CYCLES);
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= i_dq;
            r_ceN   <= 1'b1;
            r_oeN   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_WR_SETUP: begin
          r_weN   <= 1'b0;
          r_cnt   <= 4'(WAIT_CYCLES);
          r_state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (r_cnt == 4'd0) begin
            r_weN   <= 1'b1;
            r_state <= ST_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // Data stays driven one cycle past the we_n rising edge for hold time.
        ST_WR_HOLD: begin
          r_ceN   <= 1'b1;
          r_dqOe  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rdata    = r_rdata;
  assign o_done     = r_done;
  assign o_sramAddr = r_addr;
  assign o_dq       = r_dq;
  assign o_dqOe     = r_dqOe;
  assign o_ceN      = r_ceN;
  assign o_oeN      = r_oeN;
  assign o_weN      = r_weN;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single SRAM port between instruction fetch and the MEM
// stage, alternating on conflict and stalling the pipeline while busy.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  logic                  w_grantAny;
  logic                  w_grantDm;
  logic                  w_misalign;
  logic                  w_start;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  logic                  r_busy;
  logic                  r_misPulse;
  req_id_e               r_lastGrant;

  // dm wins a conflict unless it also won the previous grant.
  assign w_grantAny = ~r_busy & (bus.if_req | bus.dm_req);
  assign w_grantDm  = bus.dm_req & (~bus.if_req | (r_lastGrant == REQ_IF));
  assign w_misalign = w_grantDm & is_misaligned(bus.dm_addr[1:0]);
  assign w_start    = w_grantAny & ~w_misalign;
  assign w_addr     = w_grantDm ? bus.dm_addr[ADDR_WIDTH+1:2] : bus.if_addr[ADDR_WIDTH+1:2];
  assign w_unused   = ^{bus.if_addr[31:ADDR_WIDTH+2], bus.if_addr[1:0],
                        bus.dm_addr[31:ADDR_WIDTH+2]};

  // r_lastGrant doubles as the ID of the access in flight; busy spans grant..done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy      <= 1'b0;
      r_misPulse  <= 1'b0;
      r_lastGrant <= REQ_IF;
    end else begin
      r_misPulse <= 1'b0;
      if (w_grantAny) begin
        r_busy      <= 1'b1;
        r_misPulse  <= w_misalign;
        r_lastGrant <= w_grantDm ? REQ_DM : REQ_IF;
      end else if (w_done | r_misPulse) begin
        r_busy <= 1'b0;
      end
    end
  end

  mem_arbiter_sram_port_ctrl #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_port (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_we       (w_grantDm & bus.dm_we),
    .i_addr     (w_addr),
    .i_wdata    (bus.dm_wdata),
    .i_dq       (bus.sram_dq_i),
    .o_rdata    (w_rdata),
    .o_done     (w_done),
    .o_sramAddr (bus.sram_addr),
    .o_dq       (bus.sram_dq_o),
    .o_dqOe     (bus.sram_dq_oe),
    .o_ceN      (bus.sram_ce_n),
    .o_oeN      (bus.sram_oe_n),
    .o_weN      (bus.sram_we_n)
  );

  assign bus.if_ready    = w_done & (r_lastGrant == REQ_IF);
  assign bus.dm_ready    = (w_done & (r_lastGrant == REQ_DM)) | r_misPulse;
  assign bus.dm_misalign = r_misPulse;
  assign bus.if_rdata    = (r_lastGrant == REQ_IF) ? w_rdata : '0;
  assign bus.dm_rdata    = (r_lastGrant == REQ_DM) ? w_rdata : '0;
  assign bus.stall       = (bus.if_req & ~bus.if_ready) | (bus.dm_req & ~bus.dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-exact directed checks at WAIT_CYCLES=1 and 0,
// then random traffic against a word-array memory model and latency rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(20)) bus0 ();
  mem_arbiter_if #(.ADDR_WIDTH(20)) bus1 ();

  mem_arbiter #(.ADDR_WIDTH(20), .WAIT_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_arbiter #(.ADDR_WIDTH(20), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  bit   [31:0] mem0 [256];
  bit   [31:0] mem1 [256];
  int unsigned refMem0 [256];
  int unsigned refMem1 [256];
  logic        pokeEn;
  logic [7:0]  pokeAddr;
  logic [31:0] pokeData;
  int errors = 0;
  int checks = 0;

  assign bus0.sram_dq_i = (!bus0.sram_ce_n && !bus0.sram_oe_n) ? mem0[bus0.sram_addr[7:0]] : 32'h0;
  assign bus1.sram_dq_i = (!bus1.sram_ce_n && !bus1.sram_oe_n) ? mem1[bus1.sram_addr[7:0]] : 32'h0;

  // Simple SRAM: a write lands on every edge where ce_n, we_n are low and data is driven.
  always @(posedge clk) begin
    if (!bus0.sram_ce_n && !bus0.sram_we_n && bus0.sram_dq_oe)
      mem0[bus0.sram_addr[7:0]] <= bus0.sram_dq_o;
    if (!bus1.sram_ce_n && !bus1.sram_we_n && bus1.sram_dq_oe)
      mem1[bus1.sram_addr[7:0]] <= bus1.sram_dq_o;
    if (pokeEn) begin
      mem0[pokeAddr] <= pokeData;
      mem1[pokeAddr] <= pokeData;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pokeWord(input logic [7:0] word, input logic [31:0] data);
    @(negedge clk);
    pokeEn = 1'b1; pokeAddr = word; pokeData = data;
    @(negedge clk);
    pokeEn = 1'b0;
    refMem0[word] = data;
    refMem1[word] = data;
  endtask

  // Issues one request on bus0, waits (bounded) for its ready and drops the request.
  task automatic applyStimulus(input bit side, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat,
                               output logic [31:0] rdata, output logic mis);
    if (side) begin
      bus0.dm_req = 1'b1; bus0.dm_we = we; bus0.dm_addr = addr; bus0.dm_wdata = wdata;
    end else begin
      bus0.if_req = 1'b1; bus0.if_addr = addr;
    end
    lat = 0; rdata = '0; mis = 1'b0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (side ? bus0.dm_ready : bus0.if_ready) begin
        rdata = side ? bus0.dm_rdata : bus0.if_rdata;
        mis   = bus0.dm_misalign;
        break;
      end
    end
    bus0.if_req = 1'b0;
    bus0.dm_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        mis;
    int          evCount;
    int          evCycle [4];
    int          evSide  [4];
    int          ceLowSeen;
    int          weLowCount;

    rst = 1'b0; pokeEn = 1'b0; pokeAddr = '0; pokeData = '0;
    bus0.if_req = 0; bus0.if_addr = '0; bus0.dm_req = 0; bus0.dm_we = 0; bus0.dm_addr = '0; bus0.dm_wdata = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.dm_req = 0; bus1.dm_we = 0; bus1.dm_addr = '0; bus1.dm_wdata = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ce_n", bus0.sram_ce_n, 1);
    checkOutput("rst_oe_n", bus0.sram_oe_n, 1);
    checkOutput("rst_we_n", bus0.sram_we_n, 1);
    checkOutput("rst_dq_oe", bus0.sram_dq_oe, 0);
    checkOutput("rst_if_ready", bus0.if_ready, 0);
    checkOutput("rst_dm_ready", bus0.dm_ready, 0);
    checkOutput("rst_if_rdata", bus0.if_rdata, 0);
    checkOutput("rst_dm_rdata", bus0.dm_rdata, 0);
    checkOutput("rst_sram_addr", 32'(bus0.sram_addr), 0);
    checkOutput("rst_sram_dq_o", bus0.sram_dq_o, 0);
    rst = 1'b1;

    pokeWord(8'd4, 32'hDEADBEEF);
    pokeWord(8'd16, 32'hCAFEF00D);

    // IF read of 0x10 with cycle-exact strobe and stall checks
    @(negedge clk);
    bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
    #1 checkOutput("ifrd_stall_c0", bus0.stall, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("ifrd_oe_n_c%0d", c), bus0.sram_oe_n, (c <= 2) ? 0 : 1);
      checkOutput($sformatf("ifrd_stall_c%0d", c), bus0.stall, (c < 3) ? 1 : 0);
      checkOutput($sformatf("ifrd_ready_c%0d", c), bus0.if_ready, (c == 3) ? 1 : 0);
      if (c == 1) checkOutput("ifrd_sram_addr", 32'(bus0.sram_addr), 4);
      if (c == 3) checkOutput("ifrd_rdata", bus0.if_rdata, 32'hDEADBEEF);
    end
    bus0.if_req = 1'b0;

    // DM write of 0x12345678 to 0x20
    @(negedge clk);
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b1; bus0.dm_addr = 32'h20; bus0.dm_wdata = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("dmwr_dq_oe_c%0d", c), bus0.sram_dq_oe, (c <= 4) ? 1 : 0);
      checkOutput($sformatf("dmwr_we_n_c%0d", c), bus0.sram_we_n, (c == 2 || c == 3) ? 0 : 1);
      checkOutput($sformatf("dmwr_ready_c%0d", c), bus0.dm_ready, (c == 5) ? 1 : 0);
    end
    bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
    refMem0[8] = 32'h12345678;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, lat, rd, mis);
    checkOutput("readback_lat", lat, 3);
    checkOutput("readback_data", rd, refMem0[8]);

    // Simultaneous requests held continuously: dm first, then strict alternation
    @(negedge clk);
    bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h40;
    evCount = 0;
    for (int k = 0; k < 4; k++) begin evCycle[k] = -1; evSide[k] = -1; end
    for (int c = 1; c <= 40 && evCount < 4; c++) begin
      @(negedge clk);
      if (bus0.dm_ready || bus0.if_ready) begin
        evCycle[evCount] = c;
        evSide[evCount]  = bus0.dm_ready ? 1 : 0;
        if (bus0.dm_ready) checkOutput("alt_dm_data", bus0.dm_rdata, refMem0[16]);
        else               checkOutput("alt_if_data", bus0.if_rdata, refMem0[4]);
        evCount++;
      end
    end
    bus0.if_req = 1'b0; bus0.dm_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("alt_side_%0d", k), evSide[k], (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("alt_cycle_%0d", k), evCycle[k], 3 + 4 * k);
    end

    // Misaligned DM access: immediate ready+misalign, no chip enable
    @(negedge clk);
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h22;
    ceLowSeen = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (!bus0.sram_ce_n) ceLowSeen++;
      if (c == 1) begin
        checkOutput("mis_ready", bus0.dm_ready, 1);
        checkOutput("mis_flag", bus0.dm_misalign, 1);
        bus0.dm_req = 1'b0;
      end
      if (c == 2) checkOutput("mis_ready_pulse", bus0.dm_ready, 0);
    end
    checkOutput("mis_no_ce", ceLowSeen, 0);

    // Reset in the middle of a write pulse
    @(negedge clk);
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b1; bus0.dm_addr = 32'h80; bus0.dm_wdata = 32'hA5A5A5A5;
    repeat (2) @(negedge clk);
    checkOutput("wrrst_in_pulse", bus0.sram_we_n, 0);
    rst = 1'b0; bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
    @(negedge clk);
    checkOutput("wrrst_we_n", bus0.sram_we_n, 1);
    checkOutput("wrrst_ce_n", bus0.sram_ce_n, 1);
    checkOutput("wrrst_dq_oe", bus0.sram_dq_oe, 0);
    checkOutput("wrrst_dm_ready", bus0.dm_ready, 0);
    checkOutput("wrrst_if_ready", bus0.if_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, mis);
    checkOutput("postrst_lat", lat, 3);
    checkOutput("postrst_data", rd, 32'hDEADBEEF);

    // Random traffic against the word-array reference (words 64..127)
    repeat (30) begin
      bit          side;
      bit          we;
      int          word;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          expMis;
      side  = 1'($urandom_range(0, 1));
      we    = side ? 1'($urandom_range(0, 1)) : 1'b0;
      word  = int'($urandom_range(64, 127));
      addr  = 32'(word * 4);
      if (side && ($urandom_range(0, 5) == 0)) addr[1:0] = 2'($urandom_range(1, 3));
      wdata = $urandom;
      expMis = side && (addr[1:0] != 2'b00);
      @(negedge clk);
      applyStimulus(side, we, addr, wdata, lat, rd, mis);
      checkOutput("rand_lat", lat, expMis ? 1 : (we ? 5 : 3));
      checkOutput("rand_mis", mis, expMis);
      if (!expMis && !we) checkOutput("rand_rdata", rd, refMem0[word]);
      if (!expMis && we) refMem0[word] = wdata;
    end

    // WAIT_CYCLES=0 instance: read ready in cycle 2, write in cycle 4, one-cycle we_n
    @(negedge clk);
    bus1.if_req = 1'b1; bus1.if_addr = 32'h10;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("w0rd_ready_c%0d", c), bus1.if_ready, (c == 2) ? 1 : 0);
      if (c == 2) checkOutput("w0rd_data", bus1.if_rdata, refMem1[4]);
    end
    bus1.if_req = 1'b0;
    @(negedge clk);
    bus1.dm_req = 1'b1; bus1.dm_we = 1'b1; bus1.dm_addr = 32'h20; bus1.dm_wdata = 32'h0BADCAFE;
    weLowCount = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (!bus1.sram_we_n) weLowCount++;
      checkOutput($sformatf("w0wr_ready_c%0d", c), bus1.dm_ready, (c == 4) ? 1 : 0);
    end
    bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    refMem1[8] = 32'h0BADCAFE;
    checkOutput("w0wr_we_pulse", weLowCount, 1);
    @(negedge clk);
    bus1.if_req = 1'b1; bus1.if_addr = 32'h20;
    repeat (2) @(negedge clk);
    checkOutput("w0rb_ready", bus1.if_ready, 1);
    checkOutput("w0rb_data", bus1.if_rdata, refMem1[8]);
    bus1.if_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
